// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: in-order queue of predicted branches, BTB feedback and mispredict flush.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enq_valid,
    output logic        enq_ready,
    input  logic [0:31] enq_PC,
    input  logic        enq_taken,
    input  logic [0:31] enq_predictedPC,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [0:31] res_target,
    output logic        fb_en,
    output logic [0:31] fb_PC,
    output logic [0:31] fb_predictedPC,
    output logic        fb_taken,
    output logic        flush,
    output logic [0:31] redirectPC,
`ifdef BRU_STATS_EN
    output logic [0:31] stat_branches,
    output logic [0:31] stat_mispredicts,
`endif
    output logic        res_err
);

    localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

    logic [0:31]      r_pc   [DEPTH];
    logic             r_tk   [DEPTH];
    logic [0:31]      r_pred [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_enq;
    logic             w_res;
    logic             w_mis;
    logic [0:31]      w_headPC;
    logic             w_headTk;
    logic [0:31]      w_headPred;

    assign w_headPC   = r_pc[r_head];
    assign w_headTk   = r_tk[r_head];
    assign w_headPred = r_pred[r_head];

    // The flush cycle blocks issue so wrong-path branches never enter the queue.
    assign enq_ready = (r_count < C_FULL) && !flush;
    assign w_enq     = enq_valid && enq_ready;
    assign w_res     = res_valid && (r_count != '0);
    assign w_mis     = w_res && ((w_headTk != res_taken) ||
                                 (res_taken && (w_headPred != res_target)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            fb_en          <= 1'b0;
            fb_PC          <= '0;
            fb_predictedPC <= '0;
            fb_taken       <= 1'b0;
            flush          <= 1'b0;
            redirectPC     <= '0;
            res_err        <= 1'b0;
        end else begin
            fb_en   <= w_res;
            flush   <= w_mis;
            res_err <= res_valid && (r_count == '0);

            if (w_res) begin
                fb_PC          <= w_headPC;
                fb_predictedPC <= res_target;
                fb_taken       <= res_taken;
            end

            if (w_mis) begin
                redirectPC <= res_taken ? res_target : (w_headPC + 32'd4);
            end

            if (w_enq) begin
                r_pc[r_tail]   <= enq_PC;
                r_tk[r_tail]   <= enq_taken;
                r_pred[r_tail] <= enq_predictedPC;
            end

            // A mispredict discards everything younger, including a same-cycle enqueue.
            if (w_mis) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_res) begin
                    r_head <= r_head + 1'b1;
                end
                if (w_enq && !w_res) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_enq && w_res) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (w_res && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (w_mis && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by randomized traffic
// compared against a queue-based reference model of the branch pipe.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        enqValid;
   logic        enqReady;
   logic [0:31] enqPc;
   logic        enqTaken;
   logic [0:31] enqPred;
   logic        resValid;
   logic        resTaken;
   logic [0:31] resTarget;
   logic        fbEn;
   logic [0:31] fbPc;
   logic [0:31] fbPred;
   logic        fbTaken;
   logic        flushOut;
   logic [0:31] redirectPc;
   logic        resErr;
`ifdef BRU_STATS_EN
   logic [0:31] statBranches;
   logic [0:31] statMispredicts;
`endif

   typedef struct {
      logic [31:0] pc;
      logic        tk;
      logic [31:0] pred;
   } entry_t;

   entry_t      modelQ[$];
   logic        modelFlush;
   int unsigned modelBranches;
   int unsigned modelMispredicts;
   int          vecCount;
   int          missCount;

   // 100 MHz free-running clock
   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk             (clk),
      .reset           (reset),
      .enq_valid       (enqValid),
      .enq_ready       (enqReady),
      .enq_PC          (enqPc),
      .enq_taken       (enqTaken),
      .enq_predictedPC (enqPred),
      .res_valid       (resValid),
      .res_taken       (resTaken),
      .res_target      (resTarget),
      .fb_en           (fbEn),
      .fb_PC           (fbPc),
      .fb_predictedPC  (fbPred),
      .fb_taken        (fbTaken),
      .flush           (flushOut),
      .redirectPC      (redirectPc),
`ifdef BRU_STATS_EN
      .stat_branches   (statBranches),
      .stat_mispredicts(statMispredicts),
`endif
      .res_err         (resErr)
   );

   // One comparison: bumps the vector count and records a miscompare on failure
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      assert (obs === exp) else begin
         missCount++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs, predicts the next-cycle outputs from the model, then checks them
   task automatic applyStimulus(input logic ev, input logic [31:0] pc, input logic tk,
                                input logic [31:0] pred, input logic rv, input logic rt,
                                input logic [31:0] rtgt);
      logic   ready;
      logic   enqFire;
      logic   resFire;
      logic   mis;
      logic   expErr;
      entry_t head;
      enqValid  = ev;
      enqPc     = pc;
      enqTaken  = tk;
      enqPred   = pred;
      resValid  = rv;
      resTaken  = rt;
      resTarget = rtgt;
      ready   = (modelQ.size() < 4) && !modelFlush;
      enqFire = ev && ready;
      resFire = rv && (modelQ.size() != 0);
      expErr  = rv && (modelQ.size() == 0);
      head    = '{pc: 32'd0, tk: 1'b0, pred: 32'd0};
      if (resFire) head = modelQ[0];
      mis = resFire && ((head.tk != rt) || (rt && (head.pred != rtgt)));
      @(posedge clk);
      #1;
      checkOutput("fb_en", {31'd0, fbEn}, {31'd0, resFire});
      if (resFire) begin
         checkOutput("fb_PC", fbPc, head.pc);
         checkOutput("fb_predictedPC", fbPred, rtgt);
         checkOutput("fb_taken", {31'd0, fbTaken}, {31'd0, rt});
      end
      checkOutput("flush", {31'd0, flushOut}, {31'd0, mis});
      if (mis) checkOutput("redirectPC", redirectPc, rt ? rtgt : head.pc + 32'd4);
      checkOutput("res_err", {31'd0, resErr}, {31'd0, expErr});
      if (resFire) begin
         void'(modelQ.pop_front());
         if (modelBranches != 32'hFFFF_FFFF) modelBranches++;
      end
      if (enqFire) modelQ.push_back('{pc: pc, tk: tk, pred: pred});
      if (mis) begin
         modelQ.delete();
         if (modelMispredicts != 32'hFFFF_FFFF) modelMispredicts++;
      end
      modelFlush = mis;
      checkOutput("enq_ready", {31'd0, enqReady}, {31'd0, (modelQ.size() < 4) && !modelFlush});
`ifdef BRU_STATS_EN
      checkOutput("stat_branches", statBranches, modelBranches);
      checkOutput("stat_mispredicts", statMispredicts, modelMispredicts);
`endif
   endtask

   // Reset with live traffic on the inputs; everything must come back cleared
   task automatic applyReset();
      reset     = 1'b1;
      enqValid  = 1'b1;
      enqPc     = 32'h0000_0AA0;
      enqTaken  = 1'b1;
      enqPred   = 32'h0000_0BB0;
      resValid  = 1'b1;
      resTaken  = 1'b0;
      resTarget = 32'h0000_0CC0;
      @(posedge clk);
      #1;
      checkOutput("rst_fb_en", {31'd0, fbEn}, 32'd0);
      checkOutput("rst_fb_PC", fbPc, 32'd0);
      checkOutput("rst_fb_predictedPC", fbPred, 32'd0);
      checkOutput("rst_fb_taken", {31'd0, fbTaken}, 32'd0);
      checkOutput("rst_flush", {31'd0, flushOut}, 32'd0);
      checkOutput("rst_redirectPC", redirectPc, 32'd0);
      checkOutput("rst_res_err", {31'd0, resErr}, 32'd0);
      checkOutput("rst_enq_ready", {31'd0, enqReady}, 32'd1);
`ifdef BRU_STATS_EN
      checkOutput("rst_stat_branches", statBranches, 32'd0);
      checkOutput("rst_stat_mispredicts", statMispredicts, 32'd0);
`endif
      reset = 1'b0;
      modelQ.delete();
      modelFlush       = 1'b0;
      modelBranches    = 0;
      modelMispredicts = 0;
   endtask

   initial begin
      logic        ev;
      logic        tk;
      logic        rv;
      logic        rt;
      logic [31:0] pc;
      logic [31:0] pred;
      logic [31:0] rtgt;
      vecCount  = 0;
      missCount = 0;
      reset     = 1'b1;
      enqValid  = 1'b0;
      enqPc     = '0;
      enqTaken  = 1'b0;
      enqPred   = '0;
      resValid  = 1'b0;
      resTaken  = 1'b0;
      resTarget = '0;
      @(posedge clk);
      #1;
      applyReset();

      // Correct taken prediction updates the BTB without flushing
      applyStimulus(1, 32'h100, 1, 32'h200, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, 32'h200);

      // Predicted not-taken, actually taken: redirect to the computed target
      applyStimulus(1, 32'h100, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, 32'h300);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

      // Wrong-direction head with younger entries and a same-cycle enqueue, all discarded
      applyStimulus(1, 32'h140, 1, 32'h200, 0, 0, 32'h0);
      applyStimulus(1, 32'h180, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(1, 32'h1C0, 1, 32'h400, 0, 0, 32'h0);
      applyStimulus(1, 32'h500, 1, 32'h600, 1, 0, 32'h0);
      applyStimulus(1, 32'h700, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 0, 32'h0);

      // Fill, attempt overflow, resolve while full, then drain in order
      for (int i = 0; i < 4; i++) applyStimulus(1, 32'h1000 + 32'(i * 16), 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(1, 32'h2000, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(1, 32'h2010, 0, 32'h0, 1, 0, 32'h0);
      applyStimulus(1, 32'h2020, 0, 32'h0, 1, 0, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 0, 32'h0, 1, 0, 32'h0);

      // Not-taken actual on a predicted-taken branch at the top of memory wraps to 0
      applyStimulus(1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

      // Taken with the right direction but a stale target is also a mispredict
      applyStimulus(1, 32'h800, 1, 32'h900, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, 32'hA00);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

      // Reset in the middle of a populated queue
      applyStimulus(1, 32'h300, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(1, 32'h304, 0, 32'h0, 0, 0, 32'h0);
      applyReset();
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 0, 32'h0);

      // Randomized traffic; resolutions mostly agree with the queued prediction
      for (int n = 0; n < 400; n++) begin
         ev   = ($urandom_range(0, 99) < 60);
         pc   = $urandom() & 32'hFFFF_FFFC;
         tk   = $urandom_range(0, 1) == 1;
         pred = 32'h4000 + 32'($urandom_range(0, 3) * 4);
         rv   = ($urandom_range(0, 99) < 50);
         rt   = $urandom_range(0, 1) == 1;
         rtgt = 32'h4000 + 32'($urandom_range(0, 3) * 4);
         if (modelQ.size() != 0 && $urandom_range(0, 99) < 70) begin
            rt   = modelQ[0].tk;
            rtgt = modelQ[0].tk ? modelQ[0].pred : rtgt;
         end
         if ($urandom_range(0, 199) == 0) begin
            applyReset();
         end else begin
            applyStimulus(ev, pc, tk, pred, rv, rt, rtgt);
         end
      end

`ifdef BRU_STATS_EN
      // Ten resolves, three of them mispredicted, from a clean start
      applyReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 32'h5000 + 32'(i * 4), 1, 32'h6000, 0, 0, 32'h0);
         applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, (i % 3 == 0 && i > 0) ? 32'h7000 : 32'h6000);
         applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
      end
      checkOutput("stat_branches_10", statBranches, 32'd10);
      checkOutput("stat_mispredicts_3", statMispredicts, 32'd3);
      applyReset();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
